// File: rtl/sdr_ch3_arbiter_if.sv
// ----------------------------------------------------------------------------
// sdr_ch3_arbiter_if
// Bundles every non-clock signal of the SDRAM channel 3 arbiter.
//   slave  : arbiter view. It takes the ROM and CPU requests, drives the
//            SDRAM ch3 command, and returns completions and read data.
//   master : environment view (rom_loader, m72 CPU path, SDRAM controller).
// Signal groups:
//   dl_active                                  ROM download in progress
//   rom_addr/rom_din/rom_be/rom_req/rom_rdy    ROM write path, toggle handshake
//   cpu_addr/cpu_din/cpu_wr_sel/cpu_req/
//   cpu_rdy/cpu_dout                           CPU path, toggle handshake
//   sdr_addr/sdr_din/sdr_be/sdr_rnw/sdr_req/
//   sdr_rdy/sdr_dout                           SDRAM ch3 command/response
//   err                                        sticky retry-exhausted flag
// ----------------------------------------------------------------------------
interface sdr_ch3_arbiter_if #(
  parameter int ADDR_W = 24
) ();
  logic              dl_active;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_din;
  logic [1:0]        rom_be;
  logic              rom_req;
  logic              rom_rdy;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_din;
  logic [1:0]        cpu_wr_sel;
  logic              cpu_req;
  logic              cpu_rdy;
  logic [15:0]       cpu_dout;
  logic [ADDR_W-1:0] sdr_addr;
  logic [15:0]       sdr_din;
  logic [1:0]        sdr_be;
  logic              sdr_rnw;
  logic              sdr_req;
  logic              sdr_rdy;
  logic [15:0]       sdr_dout;
  logic              err;

  modport slave (
    input  dl_active,
    input  rom_addr, rom_din, rom_be, rom_req,
    output rom_rdy,
    input  cpu_addr, cpu_din, cpu_wr_sel, cpu_req,
    output cpu_rdy, cpu_dout,
    output sdr_addr, sdr_din, sdr_be, sdr_rnw, sdr_req,
    input  sdr_rdy, sdr_dout,
    output err
  );

  modport master (
    output dl_active,
    output rom_addr, rom_din, rom_be, rom_req,
    input  rom_rdy,
    output cpu_addr, cpu_din, cpu_wr_sel, cpu_req,
    input  cpu_rdy, cpu_dout,
    input  sdr_addr, sdr_din, sdr_be, sdr_rnw, sdr_req,
    output sdr_rdy, sdr_dout,
    input  err
  );
endinterface

// File: rtl/sdr_ch3_arbiter.sv
// ----------------------------------------------------------------------------
// sdr_ch3_arbiter
// Sequential arbiter for SDRAM channel 3 between the ROM download path and
// the CPU memory path. It latches one request at a time and issues it as a
// single-cycle sdr_req pulse. If sdr_rdy does not come back in time, it
// reissues the request. ROM writes have priority, and CPU accesses are held
// off while dl_active is high. Runs in the SDRAM clock domain (CLK_96M).
//
// Ports:
//   clk      SDRAM clock
//   reset_n  asynchronous active-low reset
//   bus      sdr_ch3_arbiter_if.slave: upstream toggle handshakes,
//            SDRAM ch3 command/response and the sticky err flag
// Optional (macro SDR_CH3_STATS_EN):
//   stat_clr       synchronous clear of all statistics
//   stat_rom_cnt   completed ROM transfers, saturating
//   stat_cpu_cnt   completed CPU transfers, saturating
//   stat_max_wait  longest WAIT residency of any single transfer
//
// Parameters:
//   ADDR_W     word address width
//   TIMEOUT    WAIT cycles (counter value) before a request is reissued
//   MAX_RETRY  reissues allowed before err is raised
// ----------------------------------------------------------------------------
module sdr_ch3_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sdr_ch3_arbiter_if.slave     bus
`ifdef SDR_CH3_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          stat_rom_cnt,
  output logic [31:0]          stat_cpu_cnt,
  output logic [15:0]          stat_max_wait
`endif
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic       {OWN_ROM, OWN_CPU}        owner_t;

  state_t            state, state_next;
  owner_t            owner;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [RTY_W-1:0]  retry_cnt;

  logic [ADDR_W-1:0] sdr_addr_q;
  logic [15:0]       sdr_din_q;
  logic [1:0]        sdr_be_q;
  logic              sdr_rnw_q;
  logic              sdr_req_q;
  logic              rom_rdy_q;
  logic              cpu_rdy_q;
  logic [15:0]       cpu_dout_q;
  logic              err_q;

  // Decoded events of the current cycle, produced by the next-state logic.
  logic grant_rom, grant_cpu, got_rdy, do_retry, give_up;

  // A requester is pending while its request toggle differs from our rdy.
  logic rom_pend, cpu_pend;
  assign rom_pend = (bus.rom_req != rom_rdy_q);
  assign cpu_pend = (bus.cpu_req != cpu_rdy_q);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // flop samples its pre-edge inputs, whatever order the processes run in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // --------------------------------------------------------------------------
  // Next-state and event decode
  // --------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first. Without the
  // default, a path that skips an assignment would infer a latch.
  always_comb begin
    state_next = state;
    grant_rom  = 1'b0;
    grant_cpu  = 1'b0;
    got_rdy    = 1'b0;
    do_retry   = 1'b0;
    give_up    = 1'b0;
    case (state)
      IDLE: begin
        if (rom_pend) begin
          grant_rom  = 1'b1;
          state_next = ISSUE;
        end else if (cpu_pend && !bus.dl_active) begin
          grant_cpu  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // A response that arrives on the timeout cycle still counts.
        if (bus.sdr_rdy) begin
          got_rdy    = 1'b1;
          state_next = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          if (retry_cnt == RTY_LAST) begin
            give_up    = 1'b1;
            state_next = DONE;
          end else begin
            do_retry   = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath, counters and handshake outputs
  // --------------------------------------------------------------------------
  // NOTE: only control and datapath flops live here; none is a memory array,
  // so every register has a reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= OWN_ROM;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      sdr_addr_q <= '0;
      sdr_din_q  <= '0;
      sdr_be_q   <= '0;
      sdr_rnw_q  <= 1'b1;
      sdr_req_q  <= 1'b0;
      rom_rdy_q  <= 1'b0;
      cpu_rdy_q  <= 1'b0;
      cpu_dout_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (grant_rom) begin
        owner      <= OWN_ROM;
        sdr_addr_q <= bus.rom_addr;
        sdr_din_q  <= bus.rom_din;
        sdr_be_q   <= bus.rom_be;
        sdr_rnw_q  <= 1'b0;
      end else if (grant_cpu) begin
        owner      <= OWN_CPU;
        sdr_addr_q <= bus.cpu_addr;
        sdr_din_q  <= bus.cpu_din;
        sdr_be_q   <= bus.cpu_wr_sel;
        sdr_rnw_q  <= ~|bus.cpu_wr_sel;
      end

      // sdr_req is high during the single ISSUE cycle, first issue or retry.
      sdr_req_q <= (state_next == ISSUE);

      if (state == ISSUE)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (do_retry) retry_cnt <= retry_cnt + RTY_W'(1);
      if (give_up)  err_q     <= 1'b1;

      if (got_rdy && owner == OWN_CPU && sdr_rnw_q) cpu_dout_q <= bus.sdr_dout;

      if (state == DONE) begin
        retry_cnt <= '0;
        if (owner == OWN_ROM) rom_rdy_q <= ~rom_rdy_q;
        else                  cpu_rdy_q <= ~cpu_rdy_q;
      end
    end
  end

  assign bus.sdr_addr = sdr_addr_q;
  assign bus.sdr_din  = sdr_din_q;
  assign bus.sdr_be   = sdr_be_q;
  assign bus.sdr_rnw  = sdr_rnw_q;
  assign bus.sdr_req  = sdr_req_q;
  assign bus.rom_rdy  = rom_rdy_q;
  assign bus.cpu_rdy  = cpu_rdy_q;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.err      = err_q;

`ifdef SDR_CH3_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics: completion counts and longest WAIT residency per transfer
  // (accumulated across retries of that transfer).
  // --------------------------------------------------------------------------
  logic [15:0] wait_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_len      <= '0;
      stat_rom_cnt  <= '0;
      stat_cpu_cnt  <= '0;
      stat_max_wait <= '0;
    end else if (stat_clr) begin
      wait_len      <= '0;
      stat_rom_cnt  <= '0;
      stat_cpu_cnt  <= '0;
      stat_max_wait <= '0;
    end else begin
      if (grant_rom || grant_cpu)             wait_len <= '0;
      else if (state == WAIT && ~&wait_len)   wait_len <= wait_len + 16'd1;

      if (state == DONE) begin
        if (wait_len > stat_max_wait) stat_max_wait <= wait_len;
        if (owner == OWN_ROM) begin
          if (~&stat_rom_cnt) stat_rom_cnt <= stat_rom_cnt + 32'd1;
        end else begin
          if (~&stat_cpu_cnt) stat_cpu_cnt <= stat_cpu_cnt + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdr_ch3_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdr_ch3_arbiter
// Directed bench for sdr_ch3_arbiter (TIMEOUT=8, MAX_RETRY=3). A small SDRAM
// responder answers each sdr_req after a programmable delay, and a negedge
// monitor logs every issued command. The expected values below are
// hand-derived from the handshake timing:
//   rdy toggles N+3 edges after the request toggle, where N is the response
//   delay counted from the sdr_req cycle.
//   Retries are spaced 10 cycles apart (1 ISSUE + 9 WAIT cycles at TIMEOUT=8).
// ----------------------------------------------------------------------------
module tb_sdr_ch3_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sdr_ch3_arbiter_if #(.ADDR_W(24)) bus ();

  sdr_ch3_arbiter #(.ADDR_W(24), .TIMEOUT(8), .MAX_RETRY(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Command log, captured mid-cycle.
  int          req_cnt = 0;
  logic [23:0] log_addr [64];
  logic [15:0] log_din  [64];
  logic [1:0]  log_be   [64];
  logic        log_rnw  [64];
  int          log_cyc  [64];

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.sdr_req === 1'b1) begin
      if (req_cnt < 64) begin
        log_addr[req_cnt] <= bus.sdr_addr;
        log_din[req_cnt]  <= bus.sdr_din;
        log_be[req_cnt]   <= bus.sdr_be;
        log_rnw[req_cnt]  <= bus.sdr_rnw;
        log_cyc[req_cnt]  <= cyc;
      end
      req_cnt <= req_cnt + 1;
    end
  end

  // SDRAM responder: pulses sdr_rdy resp_n cycles after the sdr_req cycle.
  bit          resp_en   = 1'b0;
  int          resp_n    = 4;
  logic [15:0] resp_data = 16'h0000;

  initial begin
    bus.sdr_rdy  = 1'b0;
    bus.sdr_dout = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (resp_en && bus.sdr_req === 1'b1) begin
        repeat (resp_n) @(posedge clk);
        #1;
        bus.sdr_rdy  = 1'b1;
        bus.sdr_dout = resp_data;
        @(posedge clk); #1;
        bus.sdr_rdy  = 1'b0;
        bus.sdr_dout = 16'h0000;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits, bounded, for the chosen requester's rdy to match its req. The
  // return value is the number of edges waited.
  task automatic wait_rdy(input bit rom, output int n);
    n = 0;
    while (n < 200 && (rom ? (bus.rom_rdy !== bus.rom_req)
                           : (bus.cpu_rdy !== bus.cpu_req))) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  int base;

  initial begin
    reset_n        = 1'b0;
    bus.dl_active  = 1'b0;
    bus.rom_addr   = '0;
    bus.rom_din    = '0;
    bus.rom_be     = '0;
    bus.rom_req    = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_din    = '0;
    bus.cpu_wr_sel = '0;
    bus.cpu_req    = 1'b0;
    tick(3);

    // ---- reset values ----
    check("rst_rom_rdy",  32'(bus.rom_rdy),  32'h0);
    check("rst_cpu_rdy",  32'(bus.cpu_rdy),  32'h0);
    check("rst_cpu_dout", 32'(bus.cpu_dout), 32'h0);
    check("rst_sdr_req",  32'(bus.sdr_req),  32'h0);
    check("rst_sdr_rnw",  32'(bus.sdr_rnw),  32'h1);
    check("rst_sdr_addr", 32'(bus.sdr_addr), 32'h0);
    check("rst_err",      32'(bus.err),      32'h0);
    reset_n = 1'b1;
    tick(2);

    // ---- single CPU read, response 4 cycles after sdr_req ----
    resp_en = 1'b1; resp_n = 4; resp_data = 16'hBEEF;
    base = req_cnt;
    bus.cpu_addr = 24'h000100; bus.cpu_wr_sel = 2'b00;
    bus.cpu_req  = ~bus.cpu_req;
    wait_rdy(1'b0, n);
    check("rd_latency",  32'(n),               32'd7);
    check("rd_pulses",   32'(req_cnt - base),  32'd1);
    check("rd_rnw",      32'(log_rnw[base]),   32'h1);
    check("rd_addr",     32'(log_addr[base]),  32'h000100);
    check("rd_cpu_dout", 32'(bus.cpu_dout),    32'hBEEF);

    // ---- ROM burst of 8 with a CPU read raised mid-burst ----
    bus.dl_active = 1'b1;
    resp_n = 2; resp_data = 16'h5555;
    base = req_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.rom_addr = 24'h002000 + 24'(i);
      bus.rom_din  = 16'hA000 + 16'(i);
      bus.rom_be   = 2'((i % 3) + 1);
      if (i == 3) begin
        bus.cpu_addr   = 24'h000300;
        bus.cpu_wr_sel = 2'b00;
        bus.cpu_req    = ~bus.cpu_req;
      end
      bus.rom_req = ~bus.rom_req;
      wait_rdy(1'b1, n);
      check("burst_rom_done", 32'(bus.rom_rdy === bus.rom_req), 32'h1);
    end
    tick(5);
    check("burst_pulses",      32'(req_cnt - base),               32'd8);
    check("burst_cpu_blocked", 32'(bus.cpu_rdy !== bus.cpu_req),  32'h1);
    for (int i = 0; i < 8; i++) begin
      check("burst_addr", 32'(log_addr[base + i]), 32'h002000 + 32'(i));
      check("burst_din",  32'(log_din[base + i]),  32'h0000A000 + 32'(i));
      check("burst_be",   32'(log_be[base + i]),   32'((i % 3) + 1));
      check("burst_rnw",  32'(log_rnw[base + i]),  32'h0);
    end
    bus.dl_active = 1'b0;
    tick(1);
    check("dl_fall_grant_req",  32'(bus.sdr_req),  32'h1);
    check("dl_fall_grant_addr", 32'(bus.sdr_addr), 32'h000300);
    wait_rdy(1'b0, n);
    check("dl_fall_cpu_done", 32'(bus.cpu_rdy === bus.cpu_req), 32'h1);
    check("dl_fall_cpu_dout", 32'(bus.cpu_dout),                 32'h5555);

    // ---- simultaneous ROM and CPU, dl_active=0: ROM first ----
    resp_n = 1;
    base = req_cnt;
    bus.rom_addr = 24'h007000; bus.rom_din = 16'hAAAA; bus.rom_be = 2'b11;
    bus.cpu_addr = 24'h000800; bus.cpu_din = 16'hCCCC; bus.cpu_wr_sel = 2'b11;
    bus.rom_req = ~bus.rom_req;
    bus.cpu_req = ~bus.cpu_req;
    wait_rdy(1'b1, n);
    check("sim_rom_done",       32'(bus.rom_rdy === bus.rom_req), 32'h1);
    check("sim_cpu_still_pend", 32'(bus.cpu_rdy !== bus.cpu_req), 32'h1);
    wait_rdy(1'b0, n);
    check("sim_cpu_done",    32'(bus.cpu_rdy === bus.cpu_req), 32'h1);
    check("sim_first_addr",  32'(log_addr[base]),              32'h007000);
    check("sim_second_addr", 32'(log_addr[base + 1]),          32'h000800);
    check("sim_second_rnw",  32'(log_rnw[base + 1]),           32'h0);

    // ---- CPU write, byte select 01 ----
    bus.cpu_addr = 24'h000400; bus.cpu_din = 16'h1234; bus.cpu_wr_sel = 2'b01;
    bus.cpu_req = ~bus.cpu_req;
    wait_rdy(1'b0, n);
    check("wr_done",     32'(bus.cpu_rdy === bus.cpu_req), 32'h1);
    check("wr_rnw",      32'(bus.sdr_rnw),  32'h0);
    check("wr_be",       32'(bus.sdr_be),   32'h1);
    check("wr_din",      32'(bus.sdr_din),  32'h1234);
    check("wr_addr",     32'(bus.sdr_addr), 32'h000400);
    check("wr_cpu_dout", 32'(bus.cpu_dout), 32'h5555);

    // ---- no response: 4 issues 10 cycles apart, then err ----
    check("pre_to_err", 32'(bus.err), 32'h0);
    resp_en = 1'b0;
    base = req_cnt;
    bus.cpu_addr = 24'h000500; bus.cpu_wr_sel = 2'b00;
    bus.cpu_req = ~bus.cpu_req;
    wait_rdy(1'b0, n);
    check("to_latency", 32'(n),               32'd42);
    check("to_pulses",  32'(req_cnt - base),  32'd4);
    check("to_gap1",    32'(log_cyc[base + 1] - log_cyc[base]),     32'd10);
    check("to_gap3",    32'(log_cyc[base + 3] - log_cyc[base + 2]), 32'd10);
    check("to_err",      32'(bus.err),      32'h1);
    check("to_cpu_dout", 32'(bus.cpu_dout), 32'h5555);

    // ---- asynchronous reset mid-WAIT, then a clean transfer ----
    bus.cpu_addr = 24'h000900; bus.cpu_wr_sel = 2'b00;
    bus.cpu_req = ~bus.cpu_req;
    tick(4);
    reset_n = 1'b0;
    #1;
    check("arst_err",      32'(bus.err),      32'h0);
    check("arst_sdr_req",  32'(bus.sdr_req),  32'h0);
    check("arst_sdr_rnw",  32'(bus.sdr_rnw),  32'h1);
    check("arst_sdr_addr", 32'(bus.sdr_addr), 32'h0);
    check("arst_sdr_din",  32'(bus.sdr_din),  32'h0);
    check("arst_sdr_be",   32'(bus.sdr_be),   32'h0);
    check("arst_cpu_dout", 32'(bus.cpu_dout), 32'h0);
    check("arst_cpu_rdy",  32'(bus.cpu_rdy),  32'h0);
    check("arst_rom_rdy",  32'(bus.rom_rdy),  32'h0);
    bus.cpu_req = 1'b0;
    bus.rom_req = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    resp_en = 1'b1; resp_n = 3; resp_data = 16'h0F0F;
    bus.cpu_addr = 24'h000A00; bus.cpu_wr_sel = 2'b00;
    bus.cpu_req = ~bus.cpu_req;
    wait_rdy(1'b0, n);
    check("post_rst_latency",  32'(n),            32'd6);
    check("post_rst_cpu_dout", 32'(bus.cpu_dout), 32'h0F0F);
    check("post_rst_err",      32'(bus.err),      32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdr_ch3_arbiter.md
Name: sdr_ch3_arbiter

Overview:
Sequential arbiter between the ROM download path (rom_loader) and the CPU memory path (m72) for SDRAM channel 3. It replaces the combinational ch3 mux. Requests are latched and issued one at a time to the SDRAM controller. ROM writes get priority, and CPU accesses are held off while a download is in progress. The block runs in the SDRAM clock domain (CLK_96M).

Parameters:
- ADDR_W, 24, word address width (covers addr[24:1])
- TIMEOUT, 255, cycles to wait for sdr_rdy before a request is reissued
- MAX_RETRY, 3, reissues allowed before the error flag is raised

Ports:
- clk  in  1  SDRAM clock (CLK_96M)
- reset_n  in  1  asynchronous, active-low reset
- dl_active  in  1  ROM download in progress (level)
- rom_addr  in  ADDR_W  ROM write word address
- rom_din  in  16  ROM write data
- rom_be  in  2  ROM byte enables
- rom_req  in  1  ROM request, toggle
- rom_rdy  out  1  ROM completion, toggle
- cpu_addr  in  ADDR_W  CPU word address
- cpu_din  in  16  CPU write data
- cpu_wr_sel  in  2  CPU byte write selects; 00 means read
- cpu_req  in  1  CPU request, toggle
- cpu_rdy  out  1  CPU completion, toggle
- cpu_dout  out  16  CPU read data, held until the next CPU read completes
- sdr_addr  out  ADDR_W  to SDRAM ch3
- sdr_din  out  16  to SDRAM ch3
- sdr_be  out  2  to SDRAM ch3
- sdr_rnw  out  1  1 = read
- sdr_req  out  1  one-cycle request pulse
- sdr_rdy  in  1  one-cycle completion pulse
- sdr_dout  in  16  read data, valid while sdr_rdy is high
- err  out  1  sticky retry-exhausted flag

Behaviour:
- Handshake, upstream side:
  - A requester is pending when its req != its rdy.
  - The arbiter completes a request by toggling rdy so that rdy equals req.
  - Requesters must not change addr, data or req while pending.
- Reset values: rom_rdy=0, cpu_rdy=0, cpu_dout=0, sdr_req=0, sdr_rnw=1, sdr_addr=0, sdr_din=0, sdr_be=0, err=0. State returns to IDLE and all counters clear.
- States:
  - IDLE: choose ROM if ROM is pending. Otherwise choose CPU if CPU is pending and dl_active=0. In the same cycle latch the address, data, byte enables, rnw and the owner into the sdr_* registers, then go to ISSUE.
    - ROM transfers always use rnw=0.
    - CPU transfers use rnw = ~|cpu_wr_sel.
  - ISSUE: drive sdr_req=1 for exactly one cycle, clear the timeout counter, go to WAIT.
  - WAIT: increment the timeout counter each cycle.
    - On sdr_rdy: for a CPU read, capture sdr_dout into cpu_dout. Go to DONE.
    - If the counter reaches TIMEOUT and retries < MAX_RETRY: increment retries, go to ISSUE.
    - If the counter reaches TIMEOUT and retries == MAX_RETRY: set err, go to DONE. On this path cpu_dout is not updated.
  - DONE: toggle the owner's rdy, clear retries, go to IDLE.
- Latency, request toggle to rdy toggle with an SDRAM response N cycles after the sdr_req pulse: N+3 clk cycles. That is 1 cycle IDLE→ISSUE, 1 cycle ISSUE, N cycles of WAIT, and 1 cycle DONE.
- Simultaneous pending requests: ROM wins. The CPU is served on the next IDLE pass, provided dl_active=0.
- dl_active rising while a CPU transfer is in flight: that transfer completes normally, and further CPU requests are blocked.
- dl_active falling with a CPU request pending: the CPU request is granted in the next IDLE cycle.
- sdr_rdy outside WAIT is ignored.
- The sdr_* outputs hold their values after completion until the next grant.
- err clears only on reset.
- Asserting reset_n low mid-transfer aborts the transfer immediately. The requesters reset on the same reset_n, so toggle state stays consistent.

Optional Feature:
- Macro: SDR_CH3_STATS_EN.
- When defined, the block adds these outputs:
  - stat_rom_cnt [31:0] and stat_cpu_cnt [31:0]: completed-transfer counts, saturating.
  - stat_max_wait [15:0]: maximum number of WAIT cycles seen for any single transfer.
  - stat_clr (input, 1): when high, clears all counters synchronously.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Single CPU read: addr=0x000100, sdr_rdy 4 cycles after sdr_req with sdr_dout=0xBEEF → sdr_rnw=1, sdr_addr=0x000100, exactly one sdr_req pulse, cpu_dout=0xBEEF, cpu_rdy toggles 7 cycles after cpu_req.
- ROM burst of 8 writes with dl_active=1 → 8 sdr_req pulses with rnw=0, rom_be passed through, and addresses in order. A CPU request raised mid-burst is not granted until dl_active=0 and is then granted in the following IDLE cycle.
- ROM and CPU toggled in the same cycle with dl_active=0 → ROM granted first, CPU second, both rdy toggles observed.
- CPU write, cpu_wr_sel=01, din=0x1234 → sdr_rnw=0, sdr_be=01, sdr_din=0x1234, cpu_dout unchanged.
- sdr_rdy never asserted, TIMEOUT=8, MAX_RETRY=3 → 4 sdr_req pulses spaced 10 cycles apart, then err=1 and cpu_rdy toggles.
- reset_n pulsed low while in WAIT → all outputs return to reset values asynchronously. After release, a new request completes normally and err=0.
